vga_sprite_stage: RTL

- One display unit in the VGA pixel chain. Sits directly upstream of the screen output picker, between vga_chain_start and vga_chain_end; several instances may be daisy-chained.
- Overlays a single 16x16 one-bit-mask sprite, optionally scaled, onto the incoming RGB stream. All other chain fields are delayed to match.
- Sprite position, colour and visibility are double-buffered and committed only at frame boundaries, so the sprite never tears mid-frame.

---
 rtl/vga_sprite_stage_if.sv | 14 +
 rtl/vga_sprite_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_stage_if.sv
// VGA pixel-chain bundle passed from one display stage to the next.
interface vga;
    logic [10:0] pxl_x;
    logic [10:0] pxl_y;
    logic        en;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    modport in  (input  pxl_x, pxl_y, en, hsync, vsync, red, green, blue);
    modport out (output pxl_x, pxl_y, en, hsync, vsync, red, green, blue);
endinterface

// File: rtl/vga_sprite_stage.sv
// Sprite overlay stage for the VGA pixel chain: draws one 16x16 one-bit-mask
// sprite (optionally scaled by 2^SCALE_LOG2) over the incoming RGB stream with
// a fixed 2-cycle latency on every chain field. Position, colour and
// visibility are double-buffered and committed on the vsync assertion edge.
// Optional macro SPRITE_COLLIDE_EN: report whether the sprite covered any
// non-black pixel during the previous frame.
module vga_sprite_stage #(
    parameter int unsigned  SCALE_LOG2    = 0,
    parameter logic [255:0] SPRITE_BITMAP = 256'h0,
    parameter bit           VSYNC_POL     = 1'b0
) (
    input  logic        clk_25,
    input  logic        resetN,
    vga.in              vga_in,
    vga.out             vga_out,
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    input  logic [11:0] color,
    input  logic        visible,
    input  logic        pos_wr,
    output logic        pending,
    output logic        collision
);
    localparam int unsigned CW      = 11;
    localparam int unsigned RW      = 12;
    localparam int unsigned BOX     = 16 << SCALE_LOG2;
    localparam logic        VS_IDLE = ~VSYNC_POL;

    logic [CW-1:0] act_x, act_y, pend_x, pend_y;
    logic [11:0]   act_color, pend_color;
    logic          act_visible, pend_visible;
    logic          vs_prev;
    logic          boundary_c;

    logic [RW-1:0] rel_x_c, rel_y_c;
    logic          inbox_c;
    logic [3:0]    col_c, row_c;

    logic [CW-1:0] s1_x, s1_y;
    logic          s1_en, s1_hs, s1_vs, s1_inbox;
    logic [11:0]   s1_rgb;
    logic [3:0]    s1_col, s1_row;

    logic [7:0]    idx_c;
    logic          opaque_c;

    logic [CW-1:0] out_x, out_y;
    logic          out_en, out_hs, out_vs;
    logic [11:0]   out_rgb;

    // Frame boundary: input vsync just moved to its active level
    assign boundary_c = (vga_in.vsync == VSYNC_POL) && (vs_prev != VSYNC_POL);

    // Previous vsync for edge detection
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) vs_prev <= VS_IDLE;
        else         vs_prev <= vga_in.vsync;
    end

    // Pending capture on pos_wr, commit to active set at a frame boundary
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            act_x        <= '0;
            act_y        <= '0;
            act_color    <= '0;
            act_visible  <= 1'b0;
            pend_x       <= '0;
            pend_y       <= '0;
            pend_color   <= '0;
            pend_visible <= 1'b0;
            pending      <= 1'b0;
        end else begin
            if (boundary_c && pending) begin
                act_x       <= pend_x;
                act_y       <= pend_y;
                act_color   <= pend_color;
                act_visible <= pend_visible;
            end
            if (pos_wr) begin
                pend_x       <= pos_x;
                pend_y       <= pos_y;
                pend_color   <= color;
                pend_visible <= visible;
                pending      <= 1'b1;
            end else if (boundary_c) begin
                pending <= 1'b0;
            end
        end
    end

    // Signed, widened offset into the sprite box; negative values have bit 11 set
    always_comb begin
        rel_x_c = {1'b0, vga_in.pxl_x} - {1'b0, act_x};
        rel_y_c = {1'b0, vga_in.pxl_y} - {1'b0, act_y};
        inbox_c = !rel_x_c[RW-1] && !rel_y_c[RW-1]
                  && (rel_x_c < RW'(BOX)) && (rel_y_c < RW'(BOX));
        col_c   = 4'(rel_x_c >> SCALE_LOG2);
        row_c   = 4'(rel_y_c >> SCALE_LOG2);
    end

    // Stage 1: register chain fields together with box hit and mask coordinates
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            s1_x     <= '0;
            s1_y     <= '0;
            s1_en    <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= VS_IDLE;
            s1_rgb   <= '0;
            s1_inbox <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_x     <= vga_in.pxl_x;
            s1_y     <= vga_in.pxl_y;
            s1_en    <= vga_in.en;
            s1_hs    <= vga_in.hsync;
            s1_vs    <= vga_in.vsync;
            s1_rgb   <= {vga_in.red, vga_in.green, vga_in.blue};
            s1_inbox <= inbox_c;
            s1_col   <= col_c;
            s1_row   <= row_c;
        end
    end

    // Mask lookup for the stage-1 pixel
    always_comb begin
        idx_c    = {s1_row, s1_col};
        opaque_c = s1_inbox && act_visible && s1_en && SPRITE_BITMAP[idx_c];
    end

    // Stage 2: sprite colour over opaque pixels, everything else passes through
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            out_x   <= '0;
            out_y   <= '0;
            out_en  <= 1'b0;
            out_hs  <= 1'b1;
            out_vs  <= VS_IDLE;
            out_rgb <= '0;
        end else begin
            out_x   <= s1_x;
            out_y   <= s1_y;
            out_en  <= s1_en;
            out_hs  <= s1_hs;
            out_vs  <= s1_vs;
            out_rgb <= opaque_c ? act_color : s1_rgb;
        end
    end

    assign vga_out.pxl_x = out_x;
    assign vga_out.pxl_y = out_y;
    assign vga_out.en    = out_en;
    assign vga_out.hsync = out_hs;
    assign vga_out.vsync = out_vs;
    assign vga_out.red   = out_rgb[11:8];
    assign vga_out.green = out_rgb[7:4];
    assign vga_out.blue  = out_rgb[3:0];

`ifdef SPRITE_COLLIDE_EN
    logic hit_c;
    logic hit_acc;

    assign hit_c = opaque_c && (s1_rgb != 12'h000);

    // Accumulate hits over a frame; publish at the boundary, including that cycle's hit
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            hit_acc   <= 1'b0;
            collision <= 1'b0;
        end else if (boundary_c) begin
            collision <= hit_acc | hit_c;
            hit_acc   <= 1'b0;
        end else if (hit_c) begin
            hit_acc <= 1'b1;
        end
    end
`else
    assign collision = 1'b0;
`endif

endmodule
